// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with valid/ready handshake and registered results.
// Single-cycle ops finish in one cycle. With ALU_MULDIV_EN defined, MUL/MULHU/DIVU/REMU
// run iteratively for WIDTH+1 cycles. Without it, those four opcodes return a.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake (alu_ctrl, a, b sampled on accept)
//   out_valid/out_ready       result handshake (result, zero, overflow)
//   busy                      iterative op in progress
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t state;
    state_t state_next;
    state_t start_state;

    logic               accept;
    logic               is_iter;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   add_res;
    logic [WIDTH-1:0]   sub_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    assign shamt   = b[SHAMT_W-1:0];
    assign add_res = a + b;
    assign sub_res = a - b;
    assign accept  = in_valid & in_ready;

    // Single-cycle datapath, evaluated on the live inputs at accept time.
    always_comb begin
        alu_res = a;
        alu_ovf = 1'b0;
        unique case (alu_ctrl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = a;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op;
    logic [WIDTH-1:0]   opnd;
    // Upper half: partial product / remainder. Lower half: multiplier / quotient.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     psum;
    logic               op_div;
    logic               in_div;
    logic               last_step;
    logic [WIDTH-1:0]   iter_res;

    assign is_iter = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_MULHU) ||
                     (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);
    assign in_div  = (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);
    assign op_div  = (op == OP_DIVU) || (op == OP_REMU);
    assign hi      = prod[2*WIDTH-1:WIDTH];
    assign lo      = prod[WIDTH-1:0];
    assign last_step = (state == BUSY) && (cnt == CNT_W'(1));
    assign start_state = is_iter ? BUSY : DONE;

    // One shift-add or one restoring-divide step. A zero divisor never
    // makes the trial subtract negative, so the quotient fills with ones
    // and the remainder ends up equal to the dividend.
    always_comb begin
        rem_sh    = {hi, lo[WIDTH-1]};
        diff      = rem_sh - {1'b0, opnd};
        psum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        prod_next = {psum, lo[WIDTH-1:1]};
        if (op_div) begin
            if (!diff[WIDTH]) begin
                prod_next = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            end else begin
                prod_next = {rem_sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign iter_res = ((op == OP_MULHU) || (op == OP_REMU)) ?
                      prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            op   <= '0;
            opnd <= '0;
            prod <= '0;
        end else if (accept) begin
            cnt  <= CNT_W'(WIDTH);
            op   <= alu_ctrl;
            opnd <= in_div ? b : a;
            prod <= {{WIDTH{1'b0}}, (in_div ? a : b)};
        end else if (state == BUSY) begin
            cnt  <= cnt - CNT_W'(1);
            prod <= prod_next;
        end
    end
`else
    assign is_iter     = 1'b0;
    assign start_state = DONE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = start_state;
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_next = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                // Taking the result frees the slot for a same-cycle request.
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? start_state : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept && !is_iter) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
        end
`ifdef ALU_MULDIV_EN
        else if (last_step) begin
            result   <= iter_res;
            zero     <= (iter_res == '0);
            overflow <= 1'b0;
        end
`endif
    end

endmodule
